// File: rtl/disp_sync_gen.sv
// rtl/disp_sync_gen.sv - VGA raster timing generator; FRAME_CNT port present only with DISP_SYNC_FRAME_CNT_EN
module disp_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_DIV  = 4,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          ACLK,
  input  logic          ARST_N,
  input  logic          DISP_ON,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic [HW-1:0] HCNT,
  output logic [VW-1:0] VCNT,
  output logic          PIX_EN,
  output logic          FRAME_START
`ifdef DISP_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]   FRAME_CNT
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_DIV < 1) begin : g_param_err
    $error("disp_sync_gen: all timing parameters and PIX_DIV must be >= 1");
  end

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  // Boundaries are sized to the counter width; every one is below the total, so none truncates.
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          fs_q, fs_d;
  logic          pix_en;
`ifdef DISP_SYNC_FRAME_CNT_EN
  logic [15:0]   fcnt_q, fcnt_d;
`endif

  assign pix_en = (state_q == ST_RUN) && (div_q == DIV_LAST);

  // Next-state: divider, raster counters, and sync/DE decoded from the next counters so they never lag.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fs_d    = 1'b0;
`ifdef DISP_SYNC_FRAME_CNT_EN
    fcnt_d  = fcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        hcnt_d = '0;
        vcnt_d = '0;
        if (DISP_ON) begin
          state_d = ST_RUN;
          fs_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!DISP_ON) begin
          state_d = ST_IDLE;
          div_d   = '0;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
          if (pix_en) begin
            if (hcnt_q == H_LAST) begin
              hcnt_d = '0;
              if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
                fs_d   = 1'b1;
`ifdef DISP_SYNC_FRAME_CNT_EN
                fcnt_d = fcnt_q + 16'd1;
`endif
              end else begin
                vcnt_d = vcnt_q + VW'(1);
              end
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    de_d = (state_d == ST_RUN) && (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
    hs_d = ((state_d == ST_RUN) && (hcnt_d >= HS_BEG) && (hcnt_d < HS_END)) ? HS_ON : ~HS_ON;
    vs_d = ((state_d == ST_RUN) && (vcnt_d >= VS_BEG) && (vcnt_d < VS_END)) ? VS_ON : ~VS_ON;
  end

  // State and output registers; reset drives every output to its idle level immediately.
  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
`ifdef DISP_SYNC_FRAME_CNT_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
`ifdef DISP_SYNC_FRAME_CNT_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign PIX_EN      = pix_en;
  assign FRAME_START = fs_q;
`ifdef DISP_SYNC_FRAME_CNT_EN
  assign FRAME_CNT   = fcnt_q;
`endif

endmodule

// File: tb/tb_disp_sync_gen.sv
// tb/tb_disp_sync_gen.sv - self-checking bench for disp_sync_gen on a 10x6 raster, PIX_DIV=3
module tb_disp_sync_gen;

  localparam int HA = 6, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int PD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FL = PD * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp_on = 1'b0;
  logic       vga_hs, vga_vs, vga_de, pix_en, frame_start;
  logic [3:0] hcnt;
  logic [2:0] vcnt;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  disp_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .PIX_DIV(PD)
  ) dut (
    .ACLK(clk),
    .ARST_N(rst_n),
    .DISP_ON(disp_on),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .VGA_DE(vga_de),
    .HCNT(hcnt),
    .VCNT(vcnt),
    .PIX_EN(pix_en),
    .FRAME_START(frame_start)
`ifdef DISP_SYNC_FRAME_CNT_EN
    ,
    .FRAME_CNT(frame_cnt)
`endif
  );

`ifndef DISP_SYNC_FRAME_CNT_EN
  assign frame_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  // Model: elapsed ACLK cycles since raster start; everything else follows by arithmetic.
  logic        m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_fc = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_fc  <= 16'd0;
    end else if (m_run && disp_on) begin
      m_t <= m_t + 1;
      if ((m_t + 1) % FL == 0) m_fc <= m_fc + 16'd1;
    end else begin
      m_run <= disp_on;
      m_t   <= 0;
    end
  end

  int   c_p, c_h, c_v;
  logic c_hs, c_vs, c_de, c_pe, c_fs;
  logic [27:0] c_exp, c_got;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!m_run) begin
      c_h = 0; c_v = 0; c_hs = 1'b1; c_vs = 1'b0; c_de = 1'b0; c_pe = 1'b0; c_fs = 1'b0;
    end else begin
      c_p  = m_t / PD;
      c_h  = c_p % HT;
      c_v  = (c_p / HT) % VT;
      c_pe = (m_t % PD) == PD - 1;
      c_fs = (m_t % FL) == 0;
      c_de = (c_h < HA) && (c_v < VA);
      c_hs = !((c_h >= HA + HF) && (c_h < HA + HF + HS));
      c_vs = (c_v >= VA + VF) && (c_v < VA + VF + VS);
    end
    c_exp = {c_hs, c_vs, c_de, c_pe, c_fs, 4'(c_h), 3'(c_v), 16'd0};
    c_got = {vga_hs, vga_vs, vga_de, pix_en, frame_start, hcnt, vcnt, 16'd0};
`ifdef DISP_SYNC_FRAME_CNT_EN
    c_exp[15:0] = m_fc;
    c_got[15:0] = frame_cnt;
`endif
    n_checks = n_checks + 1;
    if (c_got !== c_exp) begin
      n_errors = n_errors + 1;
      $display("FAIL cycle_outputs t=%0t {hs,vs,de,pe,fs,h,v,fc} got=%h expected=%h", $time, c_got, c_exp);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_hv(input int h, input int v, input string name);
    int k;
    k = 0;
    while (!(hcnt == 4'(h) && vcnt == 3'(v)) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(hcnt == 4'(h) && vcnt == 3'(v)), 1);
  endtask

  task automatic wait_fs(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 400);
    check(name, int'(frame_start), 1);
  endtask

  int cyc, hs_n, de_n, vs_n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 0);
    check("rst_de", vga_de, 0);
    check("rst_pix_en", pix_en, 0);
    check("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pix_en", pix_en, 0);
    check("idle_hcnt", hcnt, 0);

    disp_on = 1'b1;
    @(negedge clk);
    check("entry_fs", frame_start, 1);
    check("entry_de", vga_de, 1);
    check("entry_hcnt", hcnt, 0);
    cyc = 0; hs_n = 0; de_n = 0; vs_n = 0;
    while (cyc < 400) begin
      if (vga_hs == 1'b0) hs_n++;
      if (vga_de) de_n++;
      if (vga_vs) vs_n++;
      if (cyc == 1) check("pix_en_second", pix_en, 0);
      if (cyc == 2) check("pix_en_third", pix_en, 1);
      if (cyc == 3) check("hcnt_after_div", hcnt, 1);
      @(negedge clk);
      cyc++;
      if (frame_start) break;
    end
    check("frame_period", cyc, 180);
    check("hs_active_cycles", hs_n, 36);
    check("de_cycles", de_n, 54);
    check("vs_active_cycles", vs_n, 30);

    wait_fs("fs_wrap2");
    wait_fs("fs_wrap3");
`ifdef DISP_SYNC_FRAME_CNT_EN
    check("frame_cnt_3", frame_cnt, 3);
`endif

    wait_hv(9, 3, "reach_9_3");
    check("vs_before_490", vga_vs, 0);
    @(negedge clk);
    wait_hv(0, 4, "reach_0_4");
    check("vs_at_line_wrap", vga_vs, 1);

    wait_hv(5, 2, "reach_5_2");
    check("de_at_5_2", vga_de, 1);
    disp_on = 1'b0;
    @(negedge clk);
    check("drop_hcnt", hcnt, 0);
    check("drop_vcnt", vcnt, 0);
    check("drop_de", vga_de, 0);
    check("drop_hs", vga_hs, 1);
    disp_on = 1'b1;
    @(negedge clk);
    check("reraise_fs", frame_start, 1);
    check("reraise_de", vga_de, 1);

    wait_hv(0, 4, "reach_vs_line");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_vs", vga_vs, 0);
    check("async_vcnt", vcnt, 0);
    check("async_hs", vga_hs, 1);
    check("async_pix_en", pix_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_fs", frame_start, 1);
    check("restart_de", vga_de, 1);
    check("restart_hcnt", hcnt, 0);
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
